uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Serial-to-parallel UART receiver: 8N1 frames, LSB first, 16x oversampling.
- Consumes the serial `sin` line and the shared `sck_rising_edge` oversample tick from the baud generator.
- Presents each received byte to the peripheral register/bus side with a one-cycle valid pulse; flags framing errors separately.
- Sits beside the UART transmitter inside the UART peripheral. Its `receiver_busy`, `rx_data_valid`, `rx_data` and `rx_error` outputs are the peripheral's receive-side status.

Parameters:
- OVERSAMPLE, 16: `sck_rising_edge` ticks per bit period.
- SAMPLE_POINT, 7: tick index within a bit (0-based) at which the bit is sampled.
- DATA_BITS, 8: data bits per frame.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-high.
- sin  in  1  serial input, asynchronous to clk, idle high.
- sck_rising_edge  in  1  one-clk-wide oversample tick, OVERSAMPLE per bit.
- receiver_busy  out  1  high while a frame is in progress.
- rx_data_valid  out  1  one-clk pulse: rx_data holds a new, correctly framed byte.
- rx_data  out  8  last correctly received byte; holds value between frames.
- rx_error  out  1  one-clk pulse: stop bit sampled as 0.

Behaviour:
- Reset: asynchronous, applied while rst_n is high.
  - All outputs 0; state IDLE; tick counter 0; bit counter 0; shift register 0.
  - Synchronizer flops set to 1 (line idle).
- Input path: `sin` passes through a 2-flop synchronizer (sin_s). All decisions use sin_s; actions happen only in cycles where sck_rising_edge=1.
- tick_cnt: 4 bits, wraps OVERSAMPLE-1 -> 0.
- bit_cnt: 3 bits, counts 0..DATA_BITS-1.
- States and transitions:
  - IDLE: on a tick with sin_s=0 -> START, tick_cnt=0, receiver_busy=1.
  - START: each tick increments tick_cnt.
    - At tick_cnt==SAMPLE_POINT with sin_s=1: false start -> IDLE, busy=0, no pulses.
    - At tick_cnt==SAMPLE_POINT with sin_s=0: continue.
    - At tick_cnt==OVERSAMPLE-1: -> DATA, tick_cnt=0, bit_cnt=0.
  - DATA: at tick_cnt==SAMPLE_POINT, shift sin_s into the MSB of the shift register (right shift, LSB-first line order).
    - At tick_cnt==OVERSAMPLE-1: if bit_cnt==DATA_BITS-1 -> STOP, else bit_cnt++.
  - STOP: at tick_cnt==SAMPLE_POINT -> IDLE, busy=0 on the next clk.
    - sin_s=1: rx_data <= shift register; rx_data_valid=1 for exactly one clk.
    - sin_s=0: rx_error=1 for exactly one clk; rx_data unchanged.
- Returning to IDLE at mid-stop lets a back-to-back start bit be caught with no lost ticks.
- Latency: rx_data_valid/rx_error rise on the clk following the tick that samples mid-stop.
- Total from the start-bit falling edge: 9*16+8 ticks, +2 clk synchronizer delay, +1 clk.
- rx_data_valid and rx_error are never high together.
- Ticks are ignored while sck_rising_edge=0; counters hold.
- A line stuck low after a framing error:
  - The next tick re-enters START.
  - Each subsequent frame reports rx_error; no valid pulse is produced.
- Reset mid-frame: immediate return to IDLE; no pulse emitted; partial byte discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, stop) is the 2-of-3 majority of sin_s captured at ticks SAMPLE_POINT-1, SAMPLE_POINT and SAMPLE_POINT+1.
  - Decision is taken at tick SAMPLE_POINT+1.
  - Output latency grows by 1 tick.
  - The return to IDLE in STOP occurs at SAMPLE_POINT+1.
- Undefined: single sample at SAMPLE_POINT, as above.

Decomposition:
- Package uart_pkg holds:
  - rx state enum {IDLE, START, DATA, STOP};
  - constants UART_OVERSAMPLE=16, UART_SAMPLE_POINT=7, UART_DATA_BITS=8;
  - these are shared with the transmitter.
- One sub-module: uart_sync2, a 2-flop synchronizer with async reset to a parameterised value (1 here). It is reusable for other async inputs.

Test Plan:
- Send frame 0xA5 (start 0, stop 1, 16 ticks/bit) -> one rx_data_valid pulse, rx_data=0xA5, rx_error=0, receiver_busy low after mid-stop.
- Send 0x3C with stop bit 0 -> one rx_error pulse, no valid, rx_data still 0xA5; then send 0x5A normally -> valid, rx_data=0x5A.
- sin low for 3 ticks, then high -> busy rises then falls at tick 7, no valid/error, next frame 0x81 received correctly.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three valid pulses, values in order, no errors.
- Assert rst_n during bit 4 of 0xC3 -> all outputs 0 immediately; after release, frame 0x7E -> rx_data=0x7E.
- With UART_RX_MAJORITY_EN: 0xA5 with a one-tick glitch inverting sin at SAMPLE_POINT of every data bit -> rx_data=0xA5. Without the macro -> rx_data=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - frame constants (oversample ratio, mid-bit sample tick, data bits)
//   - receiver state encoding
//   - 2-of-3 majority helper, used by uart_rx_core when UART_RX_MAJORITY_EN is defined
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE   = 16;
  localparam int unsigned UART_SAMPLE_POINT = 7;
  localparam int unsigned UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic logic maj3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for a single asynchronous input.
// Both flops reset to ResetVal so the output is a known level straight out of reset.
// Ports:
//   clk_i  - destination clock
//   rst_n  - asynchronous reset, active high
//   d_i    - asynchronous input
//   q_o    - synchronized output, two clk_i cycles behind d_i
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, LSB first, oversampled by the shared baud tick.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 majority of the
// synchronized line at ticks SAMPLE_POINT-1..SAMPLE_POINT+1, decided at SAMPLE_POINT+1.
// Ports:
//   clk_i              - system clock, posedge
//   rst_n              - asynchronous reset, active high
//   sin_i              - serial input, asynchronous, idle high
//   sck_rising_edge_i  - one-cycle oversample tick, OVERSAMPLE per bit
//   receiver_busy_o    - high while a frame is in progress
//   rx_data_valid_o    - one-cycle pulse, rx_data_o holds a new correctly framed byte
//   rx_data_o          - last correctly received byte
//   rx_error_o         - one-cycle pulse, stop bit sampled low
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int unsigned SAMPLE_POINT = UART_SAMPLE_POINT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 sin_i,
  input  logic                 sck_rising_edge_i,
  output logic                 receiver_busy_o,
  output logic                 rx_data_valid_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_error_o
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  localparam logic [TickW-1:0] TickLast   = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] TickSample = TickW'(SAMPLE_POINT);
  localparam logic [BitW-1:0]  BitLast    = BitW'(DATA_BITS - 1);

  logic                 sin_s;
  rx_state_e            state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 sample_en;
  logic                 sample_bit;

  uart_sync2 #(
    .ResetVal(1'b1)
  ) u_sync_sin (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .d_i  (sin_i),
    .q_o  (sin_s)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TickW-1:0] TickEarly = TickW'(SAMPLE_POINT - 1);
  localparam logic [TickW-1:0] TickLate  = TickW'(SAMPLE_POINT + 1);

  // Line level captured at SAMPLE_POINT-1 (bit 1) and SAMPLE_POINT (bit 0).
  logic [1:0] early_q;

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      early_q <= 2'b11;
    end else if (sck_rising_edge_i && (state_q != StIdle) &&
                 ((tick_q == TickEarly) || (tick_q == TickSample))) begin
      early_q <= {early_q[0], sin_s};
    end
  end

  assign sample_en  = (tick_q == TickLate);
  assign sample_bit = maj3(early_q[1], early_q[0], sin_s);
`else
  assign sample_en  = (tick_q == TickSample);
  assign sample_bit = sin_s;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (sck_rising_edge_i) begin
      case (state_q)
        StIdle: begin
          if (!sin_s) begin
            state_d = StStart;
            tick_d  = '0;
          end
        end
        StStart: begin
          tick_d = tick_q + 1'b1;
          if (sample_en && sample_bit) begin
            // Line back high at mid-start: glitch, not a frame.
            state_d = StIdle;
            tick_d  = '0;
          end else if (tick_q == TickLast) begin
            state_d = StData;
            tick_d  = '0;
            bit_d   = '0;
          end
        end
        StData: begin
          tick_d = tick_q + 1'b1;
          if (sample_en) begin
            shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
          end
          if (tick_q == TickLast) begin
            tick_d = '0;
            if (bit_q == BitLast) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        StStop: begin
          tick_d = tick_q + 1'b1;
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (sample_en) begin
            state_d = StIdle;
            tick_d  = '0;
            if (sample_bit) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign receiver_busy_o = (state_q != StIdle);
  assign rx_data_valid_o = valid_q;
  assign rx_data_o       = data_q;
  assign rx_error_o      = err_q;

endmodule
